// File: rtl/fifo_ram_controller.sv
// First-word-fall-through FIFO controller driving an external simple dual-port RAM.
// Optional sticky overflow/underflow outputs: define FIFO_RAM_CONTROLLER_ERROR_FLAGS_EN.
module fifo_ram_controller #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [WIDTH-1:0]         write_data,
  output logic                     full,
  input  logic                     read_enable,
  output logic [WIDTH-1:0]         read_data,
  output logic                     empty,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     ram_write_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_write_address,
  output logic [WIDTH-1:0]         ram_write_data,
  output logic                     ram_read_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  input  logic [WIDTH-1:0]         ram_read_data
`ifdef FIFO_RAM_CONTROLLER_ERROR_FLAGS_EN
  ,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  // MSB of each pointer is the wrap bit; low bits address the RAM.
  logic [ADDRESS_WIDTH:0] r_write_pointer;
  logic [ADDRESS_WIDTH:0] r_read_pointer;
  logic                   w_write_accept;
  logic                   w_read_accept;

  always_comb begin
    empty = (r_write_pointer == r_read_pointer);
    full  = (r_write_pointer[ADDRESS_WIDTH-1:0] == r_read_pointer[ADDRESS_WIDTH-1:0]) &&
            (r_write_pointer[ADDRESS_WIDTH] != r_read_pointer[ADDRESS_WIDTH]);
    level = r_write_pointer - r_read_pointer;

    w_write_accept = write_enable && !full;
    w_read_accept  = read_enable && !empty;

    // RAM write is suppressed while reset is held so nothing lands during the reset edge.
    ram_write_enable  = w_write_accept && !reset;
    ram_write_address = r_write_pointer[ADDRESS_WIDTH-1:0];
    ram_write_data    = write_data;

    ram_read_enable  = !empty;
    ram_read_address = r_read_pointer[ADDRESS_WIDTH-1:0];
    read_data        = empty ? '0 : ram_read_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_write_pointer <= '0;
      r_read_pointer  <= '0;
    end else begin
      if (w_write_accept) r_write_pointer <= r_write_pointer + 1'b1;
      if (w_read_accept)  r_read_pointer  <= r_read_pointer + 1'b1;
    end
  end

`ifdef FIFO_RAM_CONTROLLER_ERROR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write_enable && full)  r_overflow  <= 1'b1;
      if (read_enable && empty)  r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule
